// File: rtl/mips16_ctrl_pkg.sv
// Shared constants for the 16-bit MIPS multicycle controller: opcodes,
// ALU operation codes, PC source selects and the controller state encoding.
package mips16_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [1:0] PC_SRC_INC = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  typedef enum logic [2:0] {
    ST_RST_IDLE = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXEC     = 3'd3,
    ST_MEM      = 3'd4,
    ST_WB       = 3'd5,
    ST_HALT     = 3'd6
  } state_e;

endpackage

// File: rtl/mips16_op_decode.sv
// Combinational opcode classifier: one-hot instruction class plus the ALU
// operation the EXEC state should request for that opcode.
module mips16_op_decode
  import mips16_ctrl_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic       rtype_o,
  output logic       imm_o,
  output logic       load_o,
  output logic       store_o,
  output logic       branch_o,
  output logic       jump_o,
  output logic       halt_o,
  output logic       illegal_o,
  output logic [2:0] alu_op_o
);

  always_comb begin
    rtype_o   = 1'b0;
    imm_o     = 1'b0;
    load_o    = 1'b0;
    store_o   = 1'b0;
    branch_o  = 1'b0;
    jump_o    = 1'b0;
    halt_o    = 1'b0;
    illegal_o = 1'b0;
    alu_op_o  = ALU_ADD;
    case (opcode_i)
      OP_ADD:  begin rtype_o = 1'b1; alu_op_o = ALU_ADD; end
      OP_SUB:  begin rtype_o = 1'b1; alu_op_o = ALU_SUB; end
      OP_AND:  begin rtype_o = 1'b1; alu_op_o = ALU_AND; end
      OP_OR:   begin rtype_o = 1'b1; alu_op_o = ALU_OR;  end
      OP_SLT:  begin rtype_o = 1'b1; alu_op_o = ALU_SLT; end
      OP_ADDI: imm_o   = 1'b1;
      OP_LW:   load_o  = 1'b1;
      OP_SW:   store_o = 1'b1;
      // The equality test for BEQ is a subtract feeding the zero flag.
      OP_BEQ:  begin branch_o = 1'b1; alu_op_o = ALU_SUB; end
      OP_JMP:  jump_o  = 1'b1;
      OP_HALT: halt_o  = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips16_multicycle_ctrl.sv
// Multicycle control FSM for the 16-bit MIPS datapath: sequences
// fetch/decode/execute/memory/writeback over one shared memory port.
module mips16_multicycle_ctrl
  import mips16_ctrl_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] Instr,
  input  logic        Zero,
  input  logic        Mem_Ready,
  output logic        Mem_Req,
  output logic        Mem_Write,
  output logic        IorD,
  output logic        IR_Write,
  output logic        PC_Write,
  output logic        Reg_Write,
  output logic [1:0]  PC_Src,
  output logic        ALU_Src,
  output logic [2:0]  ALU_Op,
  output logic        Mem_To_Reg,
  output logic        Reg_Dst,
  output logic [3:0]  Opcode,
  output logic        Halted,
  output logic        Illegal_Op,
  output logic [15:0] Retired,
  output logic [2:0]  Dbg_State
);

  // Memory handshake: Mem_Req (with IorD/Mem_Write) is raised from the
  // registered state and held unchanged until the cycle in which Mem_Ready
  // is also high; that cycle is the transfer. Mem_Ready is ignored whenever
  // Mem_Req is low.

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] retired_q, retired_d;
  logic        retire;

  logic is_rtype, is_imm, is_load, is_store, is_branch, is_jump, is_halt, is_illegal;
  logic [2:0] dec_alu_op;

  // Only the opcode field steers control; operand fields go straight to the datapath.
  logic unused_instr_fields;
  assign unused_instr_fields = ^Instr[11:0];

  mips16_op_decode u_decode (
    .opcode_i  (op_q),
    .rtype_o   (is_rtype),
    .imm_o     (is_imm),
    .load_o    (is_load),
    .store_o   (is_store),
    .branch_o  (is_branch),
    .jump_o    (is_jump),
    .halt_o    (is_halt),
    .illegal_o (is_illegal),
    .alu_op_o  (dec_alu_op)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_RST_IDLE;
      op_q      <= 4'h0;
      retired_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      ST_RST_IDLE: state_d = ST_FETCH;
      ST_FETCH:    if (Mem_Ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (is_halt) begin
          state_d = ST_HALT;
        end else if (is_illegal) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_rtype || is_imm) begin
          state_d = ST_WB;
        end else if (is_load || is_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end
      ST_MEM: begin
        if (Mem_Ready) begin
          state_d = is_store ? ST_FETCH : ST_WB;
          retire  = is_store;
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST_IDLE;
    endcase
  end

  assign op_d      = (state_q == ST_FETCH && Mem_Ready) ? Instr[15:12] : op_q;
  assign retired_d = retire ? retired_q + 16'd1 : retired_q;

  always_comb begin
    Mem_Req    = 1'b0;
    Mem_Write  = 1'b0;
    IorD       = 1'b0;
    IR_Write   = 1'b0;
    PC_Write   = 1'b0;
    Reg_Write  = 1'b0;
    PC_Src     = PC_SRC_INC;
    ALU_Src    = 1'b0;
    ALU_Op     = ALU_ADD;
    Mem_To_Reg = 1'b0;
    Reg_Dst    = 1'b0;
    Halted     = 1'b0;
    Illegal_Op = 1'b0;
    case (state_q)
      ST_FETCH: begin
        Mem_Req = 1'b1;
        if (Mem_Ready) begin
          IR_Write = 1'b1;
          PC_Write = 1'b1;
        end
      end
      ST_DECODE: Illegal_Op = is_illegal;
      ST_EXEC: begin
        ALU_Op  = dec_alu_op;
        ALU_Src = is_imm | is_load | is_store;
        if (is_branch) begin
          PC_Write = Zero;
          PC_Src   = PC_SRC_BR;
        end else if (is_jump) begin
          PC_Write = 1'b1;
          PC_Src   = PC_SRC_JMP;
        end
      end
      ST_MEM: begin
        Mem_Req   = 1'b1;
        IorD      = 1'b1;
        Mem_Write = is_store;
      end
      ST_WB: begin
        Reg_Write  = 1'b1;
        Reg_Dst    = is_rtype;
        Mem_To_Reg = is_load;
      end
      ST_HALT: Halted = 1'b1;
      default: ;
    endcase
  end

  assign Opcode    = op_q;
  assign Retired   = retired_q;
  assign Dbg_State = state_q;

endmodule

// File: tb/tb_mips16_multicycle_ctrl.sv
// Directed bench for the multicycle controller: walks each instruction class
// cycle by cycle and compares state, control bundle and retire count.
module tb_mips16_multicycle_ctrl;
  import mips16_ctrl_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [15:0] Instr;
  logic        Zero;
  logic        Mem_Ready;
  logic        Mem_Req, Mem_Write, IorD, IR_Write, PC_Write, Reg_Write;
  logic [1:0]  PC_Src;
  logic        ALU_Src;
  logic [2:0]  ALU_Op;
  logic        Mem_To_Reg, Reg_Dst, Halted, Illegal_Op;
  logic [3:0]  Opcode;
  logic [15:0] Retired;
  logic [2:0]  Dbg_State;

  mips16_multicycle_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .Instr(Instr), .Zero(Zero), .Mem_Ready(Mem_Ready),
    .Mem_Req(Mem_Req), .Mem_Write(Mem_Write), .IorD(IorD), .IR_Write(IR_Write),
    .PC_Write(PC_Write), .Reg_Write(Reg_Write), .PC_Src(PC_Src), .ALU_Src(ALU_Src),
    .ALU_Op(ALU_Op), .Mem_To_Reg(Mem_To_Reg), .Reg_Dst(Reg_Dst), .Opcode(Opcode),
    .Halted(Halted), .Illegal_Op(Illegal_Op), .Retired(Retired), .Dbg_State(Dbg_State)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_ret;

  logic [15:0] obs_ctl;
  assign obs_ctl = {Mem_Req, Mem_Write, IorD, IR_Write, PC_Write, PC_Src, ALU_Src,
                    ALU_Op, Reg_Write, Mem_To_Reg, Reg_Dst, Halted, Illegal_Op};

  function automatic logic [15:0] ctl(input logic req, input logic wr, input logic iord,
                                      input logic irw, input logic pcw, input logic [1:0] pcs,
                                      input logic alus, input logic [2:0] aluop,
                                      input logic regw, input logic m2r, input logic rdst,
                                      input logic halt, input logic ill);
    return {req, wr, iord, irw, pcw, pcs, alus, aluop, regw, m2r, rdst, halt, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered just after a falling edge: drive inputs, let comb settle,
  // compare, then advance to the next falling edge.
  task automatic exp_cycle(input string tag, input logic rdy, input logic [15:0] instr,
                           input logic zero, input logic [2:0] st, input logic [15:0] c);
    Mem_Ready = rdy;
    Instr     = instr;
    Zero      = zero;
    #1;
    check({tag, "/state"}, {29'd0, Dbg_State}, {29'd0, st});
    check({tag, "/ctl"}, {16'd0, obs_ctl}, {16'd0, c});
    @(negedge Clk);
  endtask

  task automatic fetch(input string tag, input logic [15:0] instr);
    exp_cycle({tag, "/F"}, 1'b1, instr, 1'b0, ST_FETCH,
              ctl(1, 0, 0, 1, 1, PC_SRC_INC, 0, ALU_ADD, 0, 0, 0, 0, 0));
  endtask

  task automatic decode(input string tag);
    exp_cycle({tag, "/D"}, 1'b1, 16'h0000, 1'b0, ST_DECODE, 16'h0000);
  endtask

  task automatic check_ret(input string tag);
    check({tag, "/retired"}, {16'd0, Retired}, {16'd0, exp_ret});
  endtask

  initial begin
    Reset_n = 1'b0; Instr = 16'h0; Zero = 1'b0; Mem_Ready = 1'b0;
    exp_ret = 16'h0;
    #1;
    check("rst/state", {29'd0, Dbg_State}, {29'd0, ST_RST_IDLE});
    check("rst/ctl", {16'd0, obs_ctl}, 32'd0);
    check("rst/opcode", {28'd0, Opcode}, 32'd0);
    check_ret("rst");
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    exp_cycle("idle", 1'b1, 16'h0, 1'b0, ST_RST_IDLE, 16'h0000);

    // Fetch wait: request held, no load enables until ready.
    exp_cycle("fwait", 1'b0, 16'h0123, 1'b0, ST_FETCH,
              ctl(1, 0, 0, 0, 0, PC_SRC_INC, 0, ALU_ADD, 0, 0, 0, 0, 0));
    fetch("add", 16'h0123);
    check("add/opcode", {28'd0, Opcode}, 32'h0);
    decode("add");
    exp_cycle("add/E", 1'b0, 16'h0, 1'b0, ST_EXEC, 16'h0000);
    exp_cycle("add/W", 1'b0, 16'h0, 1'b0, ST_WB,
              ctl(0, 0, 0, 0, 0, PC_SRC_INC, 0, ALU_ADD, 1, 0, 1, 0, 0));
    exp_ret++; check_ret("add");

    fetch("or", 16'h3456);
    check("or/opcode", {28'd0, Opcode}, 32'h3);
    decode("or");
    exp_cycle("or/E", 1'b0, 16'h0, 1'b0, ST_EXEC,
              ctl(0, 0, 0, 0, 0, PC_SRC_INC, 0, ALU_OR, 0, 0, 0, 0, 0));
    exp_cycle("or/W", 1'b0, 16'h0, 1'b0, ST_WB,
              ctl(0, 0, 0, 0, 0, PC_SRC_INC, 0, ALU_ADD, 1, 0, 1, 0, 0));
    exp_ret++; check_ret("or");

    fetch("lw", 16'h6125);
    decode("lw");
    check_ret("lw/notyet");
    exp_cycle("lw/E", 1'b0, 16'h0, 1'b0, ST_EXEC,
              ctl(0, 0, 0, 0, 0, PC_SRC_INC, 1, ALU_ADD, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      exp_cycle("lw/Mwait", 1'b0, 16'h0, 1'b0, ST_MEM,
                ctl(1, 0, 1, 0, 0, PC_SRC_INC, 0, ALU_ADD, 0, 0, 0, 0, 0));
    exp_cycle("lw/M", 1'b1, 16'h0, 1'b0, ST_MEM,
              ctl(1, 0, 1, 0, 0, PC_SRC_INC, 0, ALU_ADD, 0, 0, 0, 0, 0));
    exp_cycle("lw/W", 1'b0, 16'h0, 1'b0, ST_WB,
              ctl(0, 0, 0, 0, 0, PC_SRC_INC, 0, ALU_ADD, 1, 1, 0, 0, 0));
    exp_ret++; check_ret("lw");

    fetch("sw", 16'h7125);
    decode("sw");
    exp_cycle("sw/E", 1'b0, 16'h0, 1'b0, ST_EXEC,
              ctl(0, 0, 0, 0, 0, PC_SRC_INC, 1, ALU_ADD, 0, 0, 0, 0, 0));
    exp_cycle("sw/M", 1'b1, 16'h0, 1'b0, ST_MEM,
              ctl(1, 1, 1, 0, 0, PC_SRC_INC, 0, ALU_ADD, 0, 0, 0, 0, 0));
    exp_ret++; check_ret("sw");

    fetch("addi", 16'h5123);
    decode("addi");
    exp_cycle("addi/E", 1'b0, 16'h0, 1'b0, ST_EXEC,
              ctl(0, 0, 0, 0, 0, PC_SRC_INC, 1, ALU_ADD, 0, 0, 0, 0, 0));
    exp_cycle("addi/W", 1'b0, 16'h0, 1'b0, ST_WB,
              ctl(0, 0, 0, 0, 0, PC_SRC_INC, 0, ALU_ADD, 1, 0, 0, 0, 0));
    exp_ret++; check_ret("addi");

    fetch("beq1", 16'h812C);
    decode("beq1");
    exp_cycle("beq1/E", 1'b1, 16'h0, 1'b1, ST_EXEC,
              ctl(0, 0, 0, 0, 1, PC_SRC_BR, 0, ALU_SUB, 0, 0, 0, 0, 0));
    exp_ret++; check_ret("beq1");

    fetch("beq0", 16'h812C);
    decode("beq0");
    exp_cycle("beq0/E", 1'b0, 16'h0, 1'b0, ST_EXEC,
              ctl(0, 0, 0, 0, 0, PC_SRC_BR, 0, ALU_SUB, 0, 0, 0, 0, 0));
    exp_ret++; check_ret("beq0");

    fetch("jmp", 16'h9ABC);
    decode("jmp");
    exp_cycle("jmp/E", 1'b0, 16'h0, 1'b0, ST_EXEC,
              ctl(0, 0, 0, 0, 1, PC_SRC_JMP, 0, ALU_ADD, 0, 0, 0, 0, 0));
    exp_ret++; check_ret("jmp");
    check("jmp/count", {16'd0, Retired}, 32'd8);

    // Illegal opcode retires from DECODE; counter preset exercises the wrap.
    fetch("ill", 16'hA000);
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    check("ill/preset", {16'd0, Retired}, 32'hFFFF);
    exp_cycle("ill/D", 1'b0, 16'h0, 1'b0, ST_DECODE,
              ctl(0, 0, 0, 0, 0, PC_SRC_INC, 0, ALU_ADD, 0, 0, 0, 0, 1));
    exp_ret = 16'h0000; check_ret("ill/wrap");
    exp_cycle("ill/next", 1'b0, 16'h0, 1'b0, ST_FETCH,
              ctl(1, 0, 0, 0, 0, PC_SRC_INC, 0, ALU_ADD, 0, 0, 0, 0, 0));
    fetch("ld2", 16'h6125);
    decode("ld2");
    exp_cycle("ld2/E", 1'b0, 16'h0, 1'b0, ST_EXEC,
              ctl(0, 0, 0, 0, 0, PC_SRC_INC, 1, ALU_ADD, 0, 0, 0, 0, 0));
    exp_cycle("ld2/Mwait", 1'b0, 16'h0, 1'b0, ST_MEM,
              ctl(1, 0, 1, 0, 0, PC_SRC_INC, 0, ALU_ADD, 0, 0, 0, 0, 0));

    // Asynchronous reset while waiting in MEM: request must drop before any edge.
    #2;
    Reset_n = 1'b0;
    #1;
    check("arst/req", {31'd0, Mem_Req}, 32'd0);
    check("arst/state", {29'd0, Dbg_State}, {29'd0, ST_RST_IDLE});
    exp_ret = 16'h0000; check_ret("arst");
    @(negedge Clk);
    Reset_n = 1'b1;
    exp_cycle("arst/idle", 1'b1, 16'h0, 1'b0, ST_RST_IDLE, 16'h0000);

    fetch("halt", 16'hF000);
    check("halt/opcode", {28'd0, Opcode}, 32'hF);
    decode("halt");
    for (int i = 0; i < 4; i++)
      exp_cycle("halt/H", 1'($urandom_range(0, 1)), 16'h0123, 1'b1, ST_HALT,
                ctl(0, 0, 0, 0, 0, PC_SRC_INC, 0, ALU_ADD, 0, 0, 0, 1, 0));
    check_ret("halt");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
